// File: rtl/i2c_reg_ctrl.sv
// Register-access sequencer: expands single-byte register write/read requests
// into the START/address/data/STOP byte commands executed by the I2C engine.
module i2c_reg_ctrl #(
    parameter logic [7:0] DEV_ID_DEFAULT = 8'hA0
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        wrreg_req,
    input  logic        rdreg_req,
    input  logic [7:0]  device_id,
    input  logic [15:0] addr,
    input  logic        addr_mode,
    input  logic [7:0]  wrdata,
    output logic [7:0]  rddata,
    output logic        RW_Done,
    output logic        ack,
    output logic        busy,
    output logic [5:0]  Cmd,
    output logic        Go,
    output logic [7:0]  Tx_DATA,
    input  logic [7:0]  Rx_DATA,
    input  logic        Trans_Done,
    input  logic        ack_o
);

    localparam logic [5:0] CMD_WR   = 6'h01;
    localparam logic [5:0] CMD_STA  = 6'h02;
    localparam logic [5:0] CMD_RD   = 6'h04;
    localparam logic [5:0] CMD_STO  = 6'h08;
    localparam logic [5:0] CMD_NACK = 6'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_step;
    logic        r_is_rd;
    logic [7:0]  r_dev;
    logic [15:0] r_addr;
    logic        r_mode;
    logic [7:0]  r_wdata;
    logic        r_ack;
    logic [7:0]  r_rddata;

    logic        w_accept;
    logic [2:0]  w_lstep;
    logic        w_last;
    logic        w_rd_step;
    logic [5:0]  w_cmd;
    logic [7:0]  w_tx;

    assign w_accept = wrreg_req | rdreg_req;

    // Logical step numbering always includes the high address byte; in 8-bit
    // mode the physical step skips over it.
    assign w_lstep   = (r_mode || r_step == 3'd0) ? r_step : r_step + 3'd1;
    assign w_last    = (w_lstep == (r_is_rd ? 3'd4 : 3'd3));
    assign w_rd_step = r_is_rd && (w_lstep == 3'd4);

    always_comb begin
        w_cmd = 6'h00;
        w_tx  = 8'h00;
        case (w_lstep)
            3'd0: begin
                w_cmd = CMD_STA | CMD_WR;
                w_tx  = r_dev & 8'hFE;
            end
            3'd1: begin
                w_cmd = CMD_WR;
                w_tx  = r_addr[15:8];
            end
            3'd2: begin
                w_cmd = CMD_WR;
                w_tx  = r_addr[7:0];
            end
            3'd3: begin
                if (r_is_rd) begin
                    w_cmd = CMD_STA | CMD_WR;
                    w_tx  = r_dev | 8'h01;
                end else begin
                    w_cmd = CMD_WR | CMD_STO;
                    w_tx  = r_wdata;
                end
            end
            3'd4: begin
                w_cmd = CMD_RD | CMD_NACK | CMD_STO;
                w_tx  = 8'h00;
            end
            default: begin
                w_cmd = 6'h00;
                w_tx  = 8'h00;
            end
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (Trans_Done) w_next = S_NEXT;
            S_NEXT:  w_next = w_last ? S_DONE : S_ISSUE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= S_IDLE;
            r_step   <= 3'd0;
            r_is_rd  <= 1'b0;
            r_dev    <= DEV_ID_DEFAULT;
            r_addr   <= 16'h0000;
            r_mode   <= 1'b0;
            r_wdata  <= 8'h00;
            r_ack    <= 1'b0;
            r_rddata <= 8'h00;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // Write has priority when both requests coincide
                        r_is_rd <= ~wrreg_req;
                        r_dev   <= device_id;
                        r_addr  <= addr;
                        r_mode  <= addr_mode;
                        r_wdata <= wrdata;
                        r_ack   <= 1'b0;
                        r_step  <= 3'd0;
                    end
                end
                S_WAIT: begin
                    if (Trans_Done) begin
                        if (w_rd_step) r_rddata <= Rx_DATA;
                        else           r_ack    <= r_ack | ack_o;
                    end
                end
                S_NEXT: begin
                    if (!w_last) r_step <= r_step + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_NEXT);
    assign Go      = (r_state == S_ISSUE);
    assign RW_Done = (r_state == S_DONE);
    assign Cmd     = busy ? w_cmd : 6'h00;
    assign Tx_DATA = busy ? w_tx  : 8'h00;
    assign ack     = r_ack;
    assign rddata  = r_rddata;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Bench for i2c_reg_ctrl: behavioural byte-engine model plus a request-level
// reference model of the expected byte stream, ack flag and read data.
module tb_i2c_reg_ctrl;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        wrreg_req = 1'b0;
    logic        rdreg_req = 1'b0;
    logic [7:0]  device_id = 8'h00;
    logic [15:0] addr = 16'h0000;
    logic        addr_mode = 1'b0;
    logic [7:0]  wrdata = 8'h00;
    logic [7:0]  rddata;
    logic        RW_Done;
    logic        ack;
    logic        busy;
    logic [5:0]  Cmd;
    logic        Go;
    logic [7:0]  Tx_DATA;
    logic [7:0]  Rx_DATA = 8'h00;
    logic        Trans_Done;
    logic        ack_o = 1'b0;

    logic        eng_td = 1'b0;
    logic        spur_td = 1'b0;
    assign Trans_Done = eng_td | spur_td;

    int vectors = 0;
    int miscompares = 0;

    // engine model configuration
    int          nack_at = -1;
    logic [7:0]  rx_val = 8'h00;
    int          eng_delay = 0;
    int          byte_idx = 0;
    logic [13:0] go_log[$];
    logic [13:0] exp_q[$];
    int          done_cnt = 0;
    logic [7:0]  model_rd = 8'h00;

    i2c_reg_ctrl #(.DEV_ID_DEFAULT(8'hA0)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .wrreg_req(wrreg_req), .rdreg_req(rdreg_req),
        .device_id(device_id), .addr(addr), .addr_mode(addr_mode), .wrdata(wrdata),
        .rddata(rddata), .RW_Done(RW_Done), .ack(ack), .busy(busy), .Cmd(Cmd),
        .Go(Go), .Tx_DATA(Tx_DATA), .Rx_DATA(Rx_DATA), .Trans_Done(Trans_Done),
        .ack_o(ack_o)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (RW_Done) done_cnt++;

    // Byte engine: logs each Go, waits some cycles, then pulses Trans_Done.
    always begin
        int d;
        bit aborted;
        @(negedge Clk);
        if (Rst_n && Go) begin
            go_log.push_back({Cmd, Tx_DATA});
            d = (eng_delay > 0) ? eng_delay : int'($urandom_range(1, 4));
            aborted = 1'b0;
            for (int k = 0; k < d; k++) begin
                @(posedge Clk);
                if (!Rst_n) aborted = 1'b1;
            end
            if (!aborted && Rst_n) begin
                #1;
                eng_td  = 1'b1;
                ack_o   = (nack_at == byte_idx);
                Rx_DATA = rx_val;
                @(posedge Clk);
                #1;
                eng_td  = 1'b0;
                ack_o   = 1'b0;
                Rx_DATA = $urandom();
            end
            byte_idx++;
        end
    end

    function automatic void build_exp(input bit rd, input logic [7:0] dev,
                                      input logic [15:0] a, input bit m,
                                      input logic [7:0] wd);
        exp_q.delete();
        exp_q.push_back({6'h03, dev[7:1], 1'b0});
        if (m) exp_q.push_back({6'h01, a[15:8]});
        exp_q.push_back({6'h01, a[7:0]});
        if (rd) begin
            exp_q.push_back({6'h03, dev[7:1], 1'b1});
            exp_q.push_back({6'h2C, 8'h00});
        end else begin
            exp_q.push_back({6'h09, wd});
        end
    endfunction

    task automatic drive_req(input bit wr, input bit rd, input logic [7:0] dev,
                             input logic [15:0] a, input bit m, input logic [7:0] wd);
        @(negedge Clk);
        wrreg_req = wr; rdreg_req = rd;
        device_id = dev; addr = a; addr_mode = m; wrdata = wd;
        @(negedge Clk);
        wrreg_req = 1'b0; rdreg_req = 1'b0;
        device_id = $urandom(); addr = $urandom(); wrdata = $urandom();
    endtask

    task automatic wait_done(input int start_cnt, input string name);
        int n = 0;
        while (done_cnt == start_cnt && n < 300) begin
            @(negedge Clk);
            n++;
        end
        vectors++;
        if (done_cnt == start_cnt) begin
            miscompares++;
            $display("FAIL %s timeout: no RW_Done within %0d cycles", name, n);
        end
    endtask

    // Full request with checks of byte stream, ack, rddata, RW_Done count.
    task automatic run_req(input string name, input bit rd, input logic [7:0] dev,
                           input logic [15:0] a, input bit m, input logic [7:0] wd,
                           input int nk, input logic [7:0] rx);
        int c0;
        bit exp_ack;
        build_exp(rd, dev, a, m, wd);
        exp_ack = (nk >= 0) && (nk < exp_q.size()) && !(rd && nk == exp_q.size() - 1);
        if (rd) model_rd = rx;
        go_log.delete();
        byte_idx = 0; nack_at = nk; rx_val = rx;
        c0 = done_cnt;
        drive_req(!rd, rd, dev, a, m, wd);
        wait_done(c0, name);
        repeat (6) @(negedge Clk);
        vectors++;
        if (go_log.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s nbytes: got %0d exp %0d", name, go_log.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < go_log.size(); i++) begin
            vectors++;
            if (go_log[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s byte%0d: got Cmd=%h Tx=%h exp Cmd=%h Tx=%h", name, i,
                         go_log[i][13:8], go_log[i][7:0], exp_q[i][13:8], exp_q[i][7:0]);
            end
        end
        vectors++;
        if (done_cnt - c0 != 1) begin
            miscompares++;
            $display("FAIL %s done_count: got %0d exp 1", name, done_cnt - c0);
        end
        vectors++;
        if (ack !== exp_ack) begin
            miscompares++;
            $display("FAIL %s ack: got %b exp %b", name, ack, exp_ack);
        end
        vectors++;
        if (rddata !== model_rd) begin
            miscompares++;
            $display("FAIL %s rddata: got %h exp %h", name, rddata, model_rd);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_after: got %b exp 0", name, busy);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if ({rddata, RW_Done, ack, busy, Cmd, Go, Tx_DATA} !== 31'd0) begin
            miscompares++;
            $display("FAIL %s: got rddata=%h done=%b ack=%b busy=%b Cmd=%h Go=%b Tx=%h exp all 0",
                     name, rddata, RW_Done, ack, busy, Cmd, Go, Tx_DATA);
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        check_reset_outputs("reset_values");
        Rst_n = 1'b1;
        model_rd = 8'h00;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_write();
        run_req("write8", 1'b0, 8'hA0, 16'h0012, 1'b0, 8'h5A, -1, 8'h00);
    endtask

    task automatic test_read();
        run_req("read16", 1'b1, 8'hA1, 16'h1234, 1'b1, 8'h00, -1, 8'hC3);
    endtask

    task automatic test_nack();
        run_req("nack_addr", 1'b0, 8'hA0, 16'h0044, 1'b0, 8'h77, 1, 8'h00);
        run_req("clean_after_nack", 1'b0, 8'hA0, 16'h0045, 1'b0, 8'h78, -1, 8'h00);
    endtask

    task automatic test_collision();
        int c0;
        build_exp(1'b0, 8'hB4, 16'h0033, 1'b0, 8'h99);
        go_log.delete();
        byte_idx = 0; nack_at = -1; rx_val = 8'hEE;
        c0 = done_cnt;
        drive_req(1'b1, 1'b1, 8'hB4, 16'h0033, 1'b0, 8'h99);
        repeat (2) @(negedge Clk);
        rdreg_req = 1'b1; device_id = 8'hB4; addr = 16'h0033;
        @(negedge Clk);
        rdreg_req = 1'b0;
        wait_done(c0, "collision");
        repeat (40) @(negedge Clk);
        vectors++;
        if (done_cnt - c0 != 1) begin
            miscompares++;
            $display("FAIL collision done_count: got %0d exp 1", done_cnt - c0);
        end
        vectors++;
        if (go_log.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL collision nbytes: got %0d exp %0d", go_log.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < go_log.size(); i++) begin
            vectors++;
            if (go_log[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL collision byte%0d: got %h exp %h", i, go_log[i], exp_q[i]);
            end
        end
        vectors++;
        if (rddata !== model_rd) begin
            miscompares++;
            $display("FAIL collision rddata: got %h exp %h", rddata, model_rd);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        int n = 0;
        go_log.delete();
        byte_idx = 0; nack_at = -1; rx_val = 8'h11; eng_delay = 6;
        c0 = done_cnt;
        drive_req(1'b0, 1'b1, 8'hA2, 16'h0056, 1'b0, 8'h00);
        while (go_log.size() < 2 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        vectors++;
        if (go_log.size() < 2) begin
            miscompares++;
            $display("FAIL reset_mid reach_byte2: got %0d bytes exp 2", go_log.size());
        end
        @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_async");
        model_rd = 8'h00;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        eng_delay = 0;
        repeat (10) @(negedge Clk);
        vectors++;
        if (done_cnt != c0) begin
            miscompares++;
            $display("FAIL reset_mid no_done: got %0d exp 0", done_cnt - c0);
        end
        run_req("read_after_reset", 1'b1, 8'hA2, 16'h0056, 1'b0, 8'h00, -1, 8'h3C);
    endtask

    task automatic test_spurious();
        int c0 = done_cnt;
        int g0;
        logic [7:0] rd0 = rddata;
        go_log.delete();
        g0 = go_log.size();
        @(negedge Clk);
        spur_td = 1'b1;
        Rx_DATA = 8'hDE;
        @(negedge Clk);
        spur_td = 1'b0;
        repeat (10) @(negedge Clk);
        vectors++;
        if (go_log.size() != g0 || done_cnt != c0) begin
            miscompares++;
            $display("FAIL spurious activity: got go=%0d done=%0d exp 0 0",
                     go_log.size() - g0, done_cnt - c0);
        end
        vectors++;
        if (rddata !== rd0) begin
            miscompares++;
            $display("FAIL spurious rddata: got %h exp %h", rddata, rd0);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            bit rd = 1'($urandom_range(0, 1));
            bit m = 1'($urandom_range(0, 1));
            int nb = (rd ? 4 : 3) + (m ? 1 : 0);
            int nk = int'($urandom_range(0, nb + 1)) - 1;
            run_req($sformatf("rand%0d", t), rd, 8'($urandom()), 16'($urandom()),
                    m, 8'($urandom()), nk, 8'($urandom()));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_collision();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
